uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter that generalises the existing TX control FSM into a complete frame engine. It contains the FSM, a bit-period divider, a data shift register, a parity generator and an output mux. It handles configurable data width, even or odd parity, one or two stop bits, and a runtime bit-period prescale. Back-to-back frames need no idle gap. It sits between the system register file or FIFO read side and the TX pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..16), sent LSB first.
PRESC_WIDTH, 6, width of the Prescale input.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
RST  input  1  reset; asynchronous, active-high.
P_DATA  input  DATA_WIDTH  parallel word to transmit.
Data_Valid  input  1  word on P_DATA is available.
PAR_EN  input  1  1 = insert a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
Prescale  input  PRESC_WIDTH  CLK cycles per bit; the value 0 is treated as 1.
TX_OUT  output  1  serial line, registered, idles high.
busy  output  1  a frame is in progress.
Data_Ack  output  1  one-cycle pulse when the word is accepted.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: TX_OUT=1, busy=0, Data_Ack=0, state=IDLE, all counters=0. Asserting RST mid-frame aborts the frame immediately. TX_OUT returns high asynchronously and no partial Data_Ack is issued.
- Bit period: P = max(Prescale,1) cycles. Each serial bit holds TX_OUT for exactly P cycles.
- Acceptance:
  - A word is accepted at a rising edge when Data_Valid=1 and the FSM is in IDLE, or in the final cycle of the last stop bit.
  - At that edge, P_DATA, PAR_EN, PAR_TYP, STOP2 and P are latched. These inputs have no effect until the next acceptance.
  - The parity bit is computed from the latched data: XOR of the data bits, inverted when PAR_TYP=1.
  - Data_Valid is ignored at all other times; no ack is given and no state changes.
- Output timing: in the cycle after acceptance, the state is START, TX_OUT=0, busy=1 and Data_Ack=1 (for that cycle only).
- States:
  - IDLE: TX_OUT=1, busy=0. Data_Valid -> START.
  - START: TX_OUT=0 for P cycles -> DATA.
  - DATA: TX_OUT = shift_reg[0]; the register shifts right every P cycles. After DATA_WIDTH bits -> PARITY if PAR_EN is latched, else -> STOP.
  - PARITY: TX_OUT = parity bit for P cycles -> STOP.
  - STOP: TX_OUT=1 for P cycles, or 2P cycles if STOP2 is latched. At the final cycle: Data_Valid=1 -> accept, then START with no idle cycle between frames; else -> IDLE.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) x P cycles, counted from the first START cycle to the last STOP cycle.
- busy is 1 in every non-IDLE state. It stays 1 continuously across back-to-back frames.
- Internal counters:
  - The cycle counter is PRESC_WIDTH wide, counts 0..P-1, and wraps at the end of each bit.
  - The bit counter is wide enough for DATA_WIDTH and resets on entry to DATA.
  - The stop-bit counter is 1 bit wide.
- Changing Prescale or the config inputs mid-frame has no effect on the current frame.

Test Plan:
- DATA_WIDTH=8, Prescale=4, PAR_EN=1, PAR_TYP=0, STOP2=0, P_DATA=0xA5, one-cycle Data_Valid -> Data_Ack pulses once. TX_OUT carries bits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles total), then returns high. busy falls after cycle 44.
- Same setup with PAR_TYP=1 -> parity bit=1; all other bits are unchanged.
- PAR_EN=0, STOP2=1, Prescale=0, P_DATA=0x00 -> frame 0,0,0,0,0,0,0,0,0,1,1 at 1 cycle per bit (11 cycles). Prescale 0 behaves identically to Prescale=1.
- Back-to-back: Data_Valid held high with 0x3C then 0xC3, Prescale=2 -> the second START begins in the cycle immediately after the first frame's last stop cycle. busy never drops, and exactly two Data_Ack pulses occur.
- Data_Valid asserted mid-DATA with 0xFF -> no Data_Ack and the current frame is uncorrupted. If Data_Valid is still high at the final stop cycle, 0xFF is accepted there.
- RST asserted during the DATA state of a 0x55 frame -> TX_OUT=1 and busy=0 immediately. After RST is released with Data_Valid=1, a fresh complete frame is sent.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, DATA_WIDTH data bits (LSB first), optional parity,
// one or two stop bits, runtime prescale. Frames may run back-to-back without an idle gap.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy,
  output logic                   Data_Ack
);

  localparam int unsigned BitCntWidth = $clog2(DATA_WIDTH + 1);
  localparam logic [BitCntWidth-1:0] LastBit = BitCntWidth'(DATA_WIDTH - 1);
  localparam logic [PRESC_WIDTH-1:0] OneCycle = PRESC_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESC_WIDTH-1:0] per_q, per_d;
  logic [BitCntWidth-1:0] bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   par_en_q, par_en_d;
  logic                   stop2_q, stop2_d;
  logic                   tx_q, tx_d;
  logic                   ack_q, ack_d;

  logic bit_end;
  logic last_stop;
  logic accept;

  assign bit_end   = (cnt_q == (per_q - OneCycle));
  assign last_stop = (state_q == StStop) && bit_end && (stop_cnt_q == stop2_q);
  // A word can be taken while idle or on the very last stop cycle (back-to-back frames).
  assign accept    = Data_Valid && ((state_q == StIdle) || last_stop);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    ack_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
      end
      StStart: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + OneCycle;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_cnt_q == LastBit) begin
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + OneCycle;
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d      = '0;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end else begin
          cnt_d = cnt_q + OneCycle;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (last_stop) begin
            stop_cnt_d = 1'b0;
            state_d    = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + OneCycle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      state_d    = StStart;
      cnt_d      = '0;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      shift_d    = P_DATA;
      par_d      = (^P_DATA) ^ PAR_TYP;
      par_en_d   = PAR_EN;
      stop2_d    = STOP2;
      per_d      = (Prescale == '0) ? OneCycle : Prescale;
      ack_d      = 1'b1;
    end
  end

  // TX_OUT is registered, so its next value is decoded from the next state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      per_q      <= OneCycle;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      ack_q      <= ack_d;
    end
  end

  assign TX_OUT   = tx_q;
  assign busy     = (state_q != StIdle);
  assign Data_Ack = ack_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: accepted words queue expected frames, and every cycle
// the line and busy flag are compared against the expanded bit stream.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [5:0] Prescale = '0;
  logic       TX_OUT;
  logic       busy;
  logic       Data_Ack;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
    bit         stop2;
    int         p;
  } frame_t;

  frame_t frames[$];
  bit     exp_bits[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     ack_cnt = 0;
  int     n_push  = 0;

  uart_tx_frame #(
    .DATA_WIDTH (8),
    .PRESC_WIDTH(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy),
    .Data_Ack  (Data_Ack)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void expand(input frame_t f);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(f.data[i]);
    if (f.par_en) seq.push_back((^f.data) ^ f.par_typ);
    seq.push_back(1'b1);
    if (f.stop2) seq.push_back(1'b1);
    foreach (seq[i]) for (int k = 0; k < f.p; k++) exp_bits.push_back(seq[i]);
  endfunction

  // Monitor: pops a frame on each ack and compares the line every cycle.
  always @(negedge CLK) begin
    if (RST) begin
      exp_bits.delete();
      check("rst_tx", TX_OUT, 1);
      check("rst_busy", busy, 0);
      check("rst_ack", Data_Ack, 0);
    end else begin
      if (Data_Ack) begin
        ack_cnt++;
        check("ack_gap", exp_bits.size(), 0);
        exp_bits.delete();
        if (frames.size() == 0) check("ack_unexpected", 1, 0);
        else expand(frames.pop_front());
      end
      if (exp_bits.size() > 0) begin
        check("tx_bit", TX_OUT, exp_bits.pop_front());
        check("busy_frame", busy, 1);
      end else begin
        check("idle_tx", TX_OUT, 1);
        check("idle_busy", busy, 0);
      end
    end
  end

  task automatic drive_word(input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                            input int presc);
    frame_t f;
    f.data = d; f.par_en = pe; f.par_typ = pt; f.stop2 = s2;
    f.p = (presc == 0) ? 1 : presc;
    frames.push_back(f);
    n_push++;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Prescale = 6'(presc);
    Data_Valid = 1'b1;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (Data_Ack) return;
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                      input int presc);
    drive_word(d, pe, pt, s2, presc);
    wait_ack();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!busy) begin
        repeat (2) @(negedge CLK);
        return;
      end
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    @(posedge CLK); #2 RST = 1'b0;

    send(8'hA5, 1, 0, 0, 4);
    Data_Valid = 1'b0;
    wait_idle();

    send(8'hA5, 1, 1, 0, 4);
    Data_Valid = 1'b0;
    wait_idle();

    send(8'h00, 0, 0, 1, 0);
    Data_Valid = 1'b0;
    wait_idle();
    send(8'h00, 0, 0, 1, 1);
    Data_Valid = 1'b0;
    wait_idle();

    // Back-to-back: Data_Valid stays high across both words.
    send(8'h3C, 1, 0, 0, 2);
    send(8'hC3, 1, 0, 0, 2);
    Data_Valid = 1'b0;
    wait_idle();

    // Word offered mid-DATA is only taken on the final stop cycle.
    send(8'h96, 0, 0, 1, 3);
    Data_Valid = 1'b0;
    repeat (6) @(negedge CLK);
    drive_word(8'hFF, 1, 1, 0, 5);
    wait_ack();
    Data_Valid = 1'b0;
    wait_idle();

    // Reset during DATA aborts the frame; a fresh frame follows.
    send(8'h55, 1, 0, 0, 2);
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    @(posedge CLK); #2 RST = 1'b1;
    #1;
    check("async_rst_tx", TX_OUT, 1);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge CLK);
    drive_word(8'h81, 1, 1, 1, 2);
    @(posedge CLK); #2 RST = 1'b0;
    wait_ack();
    Data_Valid = 1'b0;
    wait_idle();

    // Random frames; config inputs scrambled mid-frame must not matter.
    for (int n = 0; n < 8; n++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5));
      Data_Valid = 1'b0;
      P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      STOP2 = 1'($urandom); Prescale = 6'($urandom_range(0, 7));
      wait_idle();
    end

    check("ack_count", ack_cnt, n_push);
    check("frames_left", frames.size(), 0);
    check("bits_left", exp_bits.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
